ip_uart_rx: RTL and testbench
=============================

IP_UART_RX -- requirements
Module: ip_uart_rx

Interface
REQ-001 Parameter clk_freq, default 74250000, system clock frequency in Hz.
REQ-002 Parameter uart_freq, default 115200, baud rate in bit/s.
REQ-003 Parameter io_address, default 8'h20, base I/O port; the block decodes io_address (DATA) and io_address+1 (STATUS).
REQ-004 Port clk, input, 1, the only clock; all logic on its rising edge.
REQ-005 Port reset_n, input, 1, synchronous active-low reset.
REQ-006 Port bus_address, input, 8, I/O port address from the Z80 bus.
REQ-007 Port bus_ioreq, input, 1, I/O request qualifier.
REQ-008 Port bus_write, input, 1, 1 = write, 0 = read.
REQ-009 Port bus_valid, input, 1, access strobe.
REQ-010 Port bus_ready, output, 1, 1 = this block accepts the current access.
REQ-011 Port bus_wdata, input, 8, write data.
REQ-012 Port bus_rdata, output, 8, read data; 8'h00 whenever bus_rdata_en = 0, so it can be OR-merged.
REQ-013 Port bus_rdata_en, output, 1, one-cycle read-data-valid pulse.
REQ-014 Port uart_rx, input, 1, asynchronous serial input; idle high.

Function
REQ-015 Bit period BP = (clk_freq + uart_freq/2) / uart_freq in integer arithmetic (645 at the defaults); half period HBP = BP/2 (322).
REQ-016 uart_rx passes a 2-flop synchronizer; all receiver logic uses the synchronized value rx_s, which is 1 after reset.
REQ-017 Receiver FSM states: IDLE, START, DATA, STOP; a bit-timer counter and a 3-bit bit index.
REQ-018 IDLE: a 1->0 transition on rx_s moves to START and loads the timer with HBP.
REQ-019 START: at timer expiry, rx_s = 0 moves to DATA with timer = BP and index 0; rx_s = 1 is a glitch and returns to IDLE with no flag change.
REQ-020 DATA: at each expiry, rx_s is shifted in LSB first and the timer reloads BP; after index 7 the FSM moves to STOP.
REQ-021 STOP: at expiry, rx_s = 1 pushes the byte into the FIFO on the next cycle; rx_s = 0 sets the framing-error flag (ferr) and discards the byte. Both cases return to IDLE immediately.
REQ-022 The receive FIFO is 16 entries x 8 bits, with wrapping 4-bit read/write pointers and a 5-bit count.
REQ-023 A push while count = 16 and no pop in the same cycle drops the byte and sets the overrun flag (ovr).
REQ-024 A push and a pop in the same cycle, including when full, both take effect and count is unchanged.
REQ-025 Access hit = bus_valid & bus_ioreq & (bus_address = io_address or io_address+1).
REQ-026 bus_ready = hit, combinational; the block never inserts wait states. bus_ready = 0 when there is no hit.
REQ-027 A DATA read returns the FIFO head and pops one entry. If the FIFO is empty it returns 8'h00 and does not pop.
REQ-028 STATUS read returns {4'b0, ferr, ovr, full, not_empty} with bit0 = not_empty and bit1 = full (count = 16).
REQ-029 Read latency: bus_rdata_en = 1 and bus_rdata is valid exactly one cycle after the hit cycle; both are 0 otherwise.
REQ-030 A STATUS write clears ovr if bus_wdata[2] = 1 and clears ferr if bus_wdata[3] = 1. If a flag is set and cleared in the same cycle, set wins.
REQ-031 A DATA write is accepted (bus_ready = 1) and has no effect.
REQ-032 ovr and ferr are sticky until cleared by REQ-030 or by reset.

Reset
REQ-033 reset_n = 0 at a rising edge forces: FSM to IDLE; timer and index to 0; FIFO pointers and count to 0; ovr = 0; ferr = 0; synchronizer flops = 1; bus_rdata = 8'h00; bus_rdata_en = 0.
REQ-034 A reset asserted mid-frame abandons the frame. After release, no byte is pushed until a new falling edge follows an idle-high rx_s.

Verification
REQ-035 Send byte 8'hA5 at 115200 baud with default parameters, then read port 8'h20 -> STATUS reads 8'h01 before the DATA read; DATA returns 8'hA5 with bus_rdata_en one cycle after the hit; STATUS then reads 8'h00.
REQ-036 Send 17 bytes 8'h00..8'h10 without reading -> STATUS = 8'h07 (overrun, full, not empty); 16 DATA reads return 8'h00..8'h0F in order; a 17th read returns 8'h00 with STATUS = 8'h04.
REQ-037 Send a frame with the stop bit held low, data 8'h3C -> FIFO stays empty and STATUS = 8'h08. Then write 8'h08 to port 8'h21 -> STATUS = 8'h00.
REQ-038 Drive a 100-cycle low pulse on uart_rx (shorter than HBP) -> FSM returns to IDLE, FIFO stays empty, STATUS = 8'h00.
REQ-039 Assert reset_n = 0 for one cycle in the middle of data bit 4 of a frame -> no byte is pushed and STATUS = 8'h00. The next full frame 8'h5A is received correctly.
REQ-040 Issue a read to port 8'h30 and a write to port 8'h20 -> bus_ready = 0 with bus_rdata_en = 0 for port 8'h30; bus_ready = 1 with FIFO contents unchanged for the write to 8'h20.

Source files
------------

// File: rtl/ip_uart_rx.sv
// UART receiver (8N1) with a 16-entry receive FIFO behind a two-port Z80 I/O window:
// io_address = DATA (read pops the FIFO head), io_address+1 = STATUS / flag clear.
module ip_uart_rx #(
  parameter int unsigned clk_freq   = 74250000,
  parameter int unsigned uart_freq  = 115200,
  parameter logic [7:0]  io_address = 8'h20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] bus_address,
  input  logic       bus_ioreq,
  input  logic       bus_write,
  input  logic       bus_valid,
  output logic       bus_ready,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_rdata_en,
  input  logic       uart_rx
);

  localparam int unsigned BitPeriod  = (clk_freq + uart_freq / 2) / uart_freq;
  localparam int unsigned HalfPeriod = BitPeriod / 2;
  localparam int unsigned TimerW     = $clog2(BitPeriod + 1);
  localparam logic [TimerW-1:0] BpVal  = TimerW'(BitPeriod);
  localparam logic [TimerW-1:0] HbpVal = TimerW'(HalfPeriod);
  localparam logic [7:0] StatAddr = io_address + 8'd1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              rx_meta_q, rx_s_q, rx_prev_q;
  logic              armed_q;
  logic              push_q;
  logic [7:0]        push_data_q;
  logic              ferr_q, ovr_q;

  logic [7:0] mem_q [16];
  logic [3:0] wptr_q, rptr_q;
  logic [4:0] count_q;

  logic hit_data, hit_stat, rd_data, rd_stat, wr_stat;
  logic full, not_empty, pop, push_ok, clr_ovr, clr_ferr;
  logic unused_wdata;

  assign hit_data  = bus_valid & bus_ioreq & (bus_address == io_address);
  assign hit_stat  = bus_valid & bus_ioreq & (bus_address == StatAddr);
  assign bus_ready = hit_data | hit_stat;
  assign rd_data   = hit_data & ~bus_write;
  assign rd_stat   = hit_stat & ~bus_write;
  assign wr_stat   = hit_stat & bus_write;
  assign clr_ovr   = wr_stat & bus_wdata[2];
  assign clr_ferr  = wr_stat & bus_wdata[3];
  assign full      = (count_q == 5'd16);
  assign not_empty = (count_q != 5'd0);
  assign pop       = rd_data & not_empty;
  assign push_ok   = push_q & (~full | pop);
  assign unused_wdata = ^{bus_wdata[7:4], bus_wdata[1:0]};

  // Receiver. After reset the line must sit high for a full bit period before a
  // falling edge is trusted, so a frame cut by reset is never resynchronised mid-byte.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= StIdle;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      ferr_q      <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      push_q    <= 1'b0;
      if (clr_ferr) ferr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!armed_q) begin
            if (!rx_s_q)             timer_q <= '0;
            else if (timer_q == BpVal) armed_q <= 1'b1;
            else                     timer_q <= timer_q + 1'b1;
          end else if (rx_prev_q && !rx_s_q) begin
            state_q <= StStart;
            timer_q <= HbpVal;
          end
        end
        StStart: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else if (!rx_s_q) begin
            state_q   <= StData;
            timer_q   <= BpVal;
            bit_idx_q <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StData: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            shift_q   <= {rx_s_q, shift_q[7:1]};
            timer_q   <= BpVal;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= StStop;
          end
        end
        StStop: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            state_q <= StIdle;
            if (rx_s_q) begin
              push_q      <= 1'b1;
              push_data_q <= shift_q;
            end else begin
              ferr_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      ovr_q        <= 1'b0;
      bus_rdata    <= '0;
      bus_rdata_en <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      // Set wins over a same-cycle clear.
      if (clr_ovr) ovr_q <= 1'b0;
      if (push_q && full && !pop) ovr_q <= 1'b1;
      bus_rdata_en <= rd_data | rd_stat;
      if (rd_data)      bus_rdata <= not_empty ? mem_q[rptr_q] : 8'h00;
      else if (rd_stat) bus_rdata <= {4'b0, ferr_q, ovr_q, full, not_empty};
      else              bus_rdata <= 8'h00;
    end
  end

endmodule

// File: tb/tb_ip_uart_rx.sv
// Directed bench for ip_uart_rx: serial frames in, Z80 I/O reads/writes out, checked
// against hand-computed values. A faster baud keeps the run short.
module tb_ip_uart_rx;

  localparam int unsigned ClkFreq  = 74250000;
  localparam int unsigned UartFreq = 300000;
  localparam int Bp = 248;  // (74250000 + 150000) / 300000

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] bus_address;
  logic       bus_ioreq;
  logic       bus_write;
  logic       bus_valid;
  logic       bus_ready;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_rdata_en;
  logic       uart_rx;

  int n_tests = 0;
  int n_fail  = 0;

  ip_uart_rx #(
    .clk_freq  (ClkFreq),
    .uart_freq (UartFreq),
    .io_address(8'h20)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus_address (bus_address),
    .bus_ioreq   (bus_ioreq),
    .bus_write   (bus_write),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_rdata_en(bus_rdata_en),
    .uart_rx     (uart_rx)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic bus_access(input logic [7:0] addr, input logic wr, input logic [7:0] wdata,
                            input logic ioreq, output logic rdy, output logic [7:0] rdata,
                            output logic en);
    @(posedge clk); #1;
    bus_address = addr;
    bus_write   = wr;
    bus_wdata   = wdata;
    bus_ioreq   = ioreq;
    bus_valid   = 1'b1;
    #1 rdy = bus_ready;
    @(posedge clk); #1;
    bus_valid = 1'b0;
    bus_ioreq = 1'b0;
    bus_write = 1'b0;
    rdata = bus_rdata;
    en    = bus_rdata_en;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    logic rdy, en;
    logic [7:0] d;
    bus_access(addr, 1'b0, 8'h00, 1'b1, rdy, d, en);
    check({tag, " ready"}, {7'd0, rdy}, 8'h01);
    check({tag, " en"}, {7'd0, en}, 8'h01);
    check({tag, " data"}, d, exp);
    @(posedge clk); #1;
    check({tag, " en drop"}, {7'd0, bus_rdata_en}, 8'h00);
    check({tag, " rdata drop"}, bus_rdata, 8'h00);
  endtask

  task automatic wr_check(input string tag, input logic [7:0] addr, input logic [7:0] data);
    logic rdy, en;
    logic [7:0] d;
    bus_access(addr, 1'b1, data, 1'b1, rdy, d, en);
    check({tag, " ready"}, {7'd0, rdy}, 8'h01);
    check({tag, " en"}, {7'd0, en}, 8'h00);
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (Bp) @(posedge clk);
    #1;
  endtask

  // rst_bit >= 0 pulses reset_n for one cycle in the middle of that data bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int rst_bit);
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        uart_rx = data[i];
        repeat (Bp / 2) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (Bp - Bp / 2 - 1) @(posedge clk);
        #1;
      end else begin
        drive_bit(data[i]);
      end
    end
    drive_bit(stop_bit);
    uart_rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    logic rdy, en;
    logic [7:0] d;
    reset_n     = 1'b0;
    uart_rx     = 1'b1;
    bus_address = 8'h00;
    bus_ioreq   = 1'b0;
    bus_write   = 1'b0;
    bus_valid   = 1'b0;
    bus_wdata   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset rdata", bus_rdata, 8'h00);
    check("reset en", {7'd0, bus_rdata_en}, 8'h00);
    check("reset ready", {7'd0, bus_ready}, 8'h00);
    reset_n = 1'b1;
    idle(2 * Bp);
    rd_check("reset status", 8'h21, 8'h00);

    // Single byte.
    send_frame(8'hA5, 1'b1, -1);
    idle(10);
    rd_check("a5 status pre", 8'h21, 8'h01);
    rd_check("a5 data", 8'h20, 8'hA5);
    rd_check("a5 status post", 8'h21, 8'h00);

    // Overrun: 17 frames into a 16-deep FIFO.
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, -1);
    idle(10);
    rd_check("ovr status", 8'h21, 8'h07);
    for (int i = 0; i < 16; i++) rd_check($sformatf("ovr data %0d", i), 8'h20, 8'(i));
    rd_check("ovr empty data", 8'h20, 8'h00);
    rd_check("ovr empty status", 8'h21, 8'h04);
    wr_check("ovr clear", 8'h21, 8'h04);
    rd_check("ovr cleared", 8'h21, 8'h00);

    // Framing error.
    send_frame(8'h3C, 1'b0, -1);
    idle(2 * Bp);
    rd_check("ferr status", 8'h21, 8'h08);
    wr_check("ferr clear", 8'h21, 8'h08);
    rd_check("ferr cleared", 8'h21, 8'h00);

    // Glitch shorter than half a bit.
    @(posedge clk); #1 uart_rx = 1'b0;
    idle(100);
    #1 uart_rx = 1'b1;
    idle(2 * Bp);
    rd_check("glitch status", 8'h21, 8'h00);

    // Reset in the middle of data bit 4, then a clean frame.
    send_frame(8'h00, 1'b1, 4);
    idle(2 * Bp);
    rd_check("midreset status", 8'h21, 8'h00);
    send_frame(8'h5A, 1'b1, -1);
    idle(10);
    rd_check("5a data", 8'h20, 8'h5A);
    rd_check("5a status", 8'h21, 8'h00);

    // Address decode and DATA write.
    send_frame(8'h77, 1'b1, -1);
    idle(10);
    bus_access(8'h30, 1'b0, 8'h00, 1'b1, rdy, d, en);
    check("miss ready", {7'd0, rdy}, 8'h00);
    check("miss en", {7'd0, en}, 8'h00);
    bus_access(8'h20, 1'b0, 8'h00, 1'b0, rdy, d, en);
    check("noioreq ready", {7'd0, rdy}, 8'h00);
    check("noioreq en", {7'd0, en}, 8'h00);
    wr_check("data write", 8'h20, 8'hFF);
    rd_check("after write status", 8'h21, 8'h01);
    rd_check("after write data", 8'h20, 8'h77);
    rd_check("final status", 8'h21, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
